// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS MEM stage
// Provides the MEM-stage FSM state encoding, the writeback control bundle,
// the bubble control value and the word-alignment mask.
package mips_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;
    localparam wb_ctrl_t BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0};
    localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register
// Ports: clk/rst (async active-low); ctrl loads every cycle;
//        alu/dest load when info_en; rdata loads when rd_en;
//        mem_to_reg, reg_write, alu_q, dest_q, rdata_q are the register outputs.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  wb_ctrl_t    ctrl,
    input  logic        info_en,
    input  logic [31:0] alu,
    input  logic [4:0]  dest,
    input  logic        rd_en,
    input  logic [31:0] rdata,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [31:0] alu_q,
    output logic [4:0]  dest_q,
    output logic [31:0] rdata_q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            alu_q      <= '0;
            dest_q     <= '0;
            rdata_q    <= '0;
        end else begin
            mem_to_reg <= ctrl.mem_to_reg;
            reg_write  <= ctrl.reg_write;
            if (info_en) begin
                alu_q  <= alu;
                dest_q <= dest;
            end
            if (rd_en) rdata_q <= rdata;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with req/ack data-memory handshake
// Ports: clk, rst (async active-low); EX/MEM fields *In; memory side
//        MemReq/MemWe/MemAddr/MemWData out, MemAck/MemRData in; Stall to the
//        upstream pipeline; MEM/WB fields *Out; AddrError/BusError pulses.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        MemToRegIn,
    input  logic        RegWriteIn,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] WriteDataIn,
    input  logic [4:0]  DestinationRegIn,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic        MemToRegOut,
    output logic        RegWriteOut,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  DestinationRegOut,
    output logic        AddrError,
    output logic        BusError
);
    state_t      state, state_next;
    logic [7:0]  cnt;
    logic        lat_mem_to_reg, lat_reg_write;
    logic [4:0]  lat_dest;
    logic        access, misaligned, start, addr_bad, ack_hit, timeout_hit;
    wb_ctrl_t    wb_ctrl;
    logic        info_en, rd_en;
    logic [31:0] wb_alu;
    logic [4:0]  wb_dest;

    assign access      = MemReadIn | MemWriteIn;
    assign misaligned  = |(ALUResultIn[1:0] & ALIGN_MASK);
    assign start       = (state == IDLE) && access && !misaligned;
    assign addr_bad    = (state == IDLE) && access && misaligned;
    assign ack_hit     = (state == WAIT) && MemAck;
    // an ack arriving on the last allowed cycle takes priority over the abort
    assign timeout_hit = (state == WAIT) && !MemAck && (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? (start ? WAIT : IDLE)
                                     : ((ack_hit || timeout_hit) ? IDLE : WAIT);
    end

    always_comb begin
        // gated by rst so an abandoned access cannot stall while reset is held
        Stall   = rst & (start | ((state == WAIT) & !MemAck & !timeout_hit));
        info_en = ack_hit | ((state == IDLE) & !access);
        rd_en   = ack_hit & !MemWe;
        wb_ctrl = ack_hit ? '{mem_to_reg: lat_mem_to_reg, reg_write: lat_reg_write & !MemWe}
                : ((state == IDLE) && !access) ? '{mem_to_reg: MemToRegIn, reg_write: RegWriteIn}
                : BUBBLE;
        wb_alu  = ack_hit ? MemAddr : ALUResultIn;
        wb_dest = ack_hit ? lat_dest : DestinationRegIn;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            MemReq         <= 1'b0;
            MemWe          <= 1'b0;
            MemAddr        <= '0;
            MemWData       <= '0;
            lat_mem_to_reg <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_dest       <= '0;
            AddrError      <= 1'b0;
            BusError       <= 1'b0;
        end else begin
            AddrError <= addr_bad;
            BusError  <= timeout_hit;
            cnt       <= ((state == WAIT) && !ack_hit && !timeout_hit) ? cnt + 8'd1 : 8'd0;
            if (start) begin
                MemReq         <= 1'b1;
                MemWe          <= MemWriteIn;
                MemAddr        <= ALUResultIn;
                MemWData       <= WriteDataIn;
                lat_mem_to_reg <= MemToRegIn;
                lat_reg_write  <= RegWriteIn;
                lat_dest       <= DestinationRegIn;
            end else if (ack_hit || timeout_hit) begin
                MemReq <= 1'b0;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .ctrl       (wb_ctrl),
        .info_en    (info_en),
        .alu        (wb_alu),
        .dest       (wb_dest),
        .rd_en      (rd_en),
        .rdata      (MemRData),
        .mem_to_reg (MemToRegOut),
        .reg_write  (RegWriteOut),
        .alu_q      (ALUResultOut),
        .dest_q     (DestinationRegOut),
        .rdata_q    (ReadDataOut)
    );
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

- Pipeline MEM stage for the MIPS core. It consumes the EX/MEM register fields and runs a req/ack handshake to a variable-latency data memory.
- It stalls the upstream pipeline while an access is outstanding, then loads the MEM/WB register with read data, ALU result, destination and writeback controls.
- It also detects misaligned word addresses and memory timeouts, inserting bubbles instead of faulty writebacks.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT cycles without MemAck before abort (1..255, 8-bit counter)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- MemReadIn, MemWriteIn, MemToRegIn, RegWriteIn  in  1 each  EX/MEM control fields
- ALUResultIn  in  32  effective address / ALU result
- WriteDataIn  in  32  store data
- DestinationRegIn  in  5  writeback register number
- MemReq  out  1  memory request, held high until ack or abort
- MemWe  out  1  1 = store, 0 = load; valid while MemReq
- MemAddr  out  32  latched word address; valid while MemReq
- MemWData  out  32  latched store data; valid while MemReq
- MemAck  in  1  one-cycle completion strobe from memory
- MemRData  in  32  load data, valid in MemAck cycle
- Stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- MemToRegOut, RegWriteOut  out  1 each  MEM/WB controls
- ReadDataOut, ALUResultOut  out  32 each  MEM/WB data
- DestinationRegOut  out  5  MEM/WB destination
- AddrError  out  1  one-cycle pulse: misaligned access dropped
- BusError  out  1  one-cycle pulse: timeout abort

## Operation
- Access = MemReadIn | MemWriteIn. If both inputs are high, treat the access as a store.
- FSM states: IDLE, WAIT.
- IDLE, no access:
  - Stall=0.
  - MEM/WB loads MemToRegIn, RegWriteIn, ALUResultIn and DestinationRegIn.
  - ReadDataOut holds its previous value.
- IDLE, access, ALUResultIn[1:0]≠0:
  - Stall=0 and no request is issued.
  - AddrError pulses next cycle.
  - MEM/WB loads a bubble: RegWriteOut=0, MemToRegOut=0, other fields hold.
- IDLE, aligned access:
  - Stall=1 combinationally.
  - Latch address, data, We and controls; enter WAIT.
  - MEM/WB loads a bubble.
- WAIT:
  - MemReq=1; timeout counter increments.
  - Stall = ~MemAck; the MEM/WB register loads a bubble each non-ack cycle.
- WAIT with MemAck:
  - MEM/WB loads the latched controls, address and destination.
  - Loads capture MemRData into ReadDataOut. Stores force RegWriteOut=0.
  - Return to IDLE and clear the counter.
- WAIT, counter reaches TIMEOUT_CYCLES with no ack:
  - Drop MemReq, Stall=0.
  - BusError pulses next cycle.
  - MEM/WB loads a bubble; return to IDLE.
- MemAck in IDLE is ignored.
- Ack in the same cycle as the timeout: the ack wins.

## Timing
- Reset (rst=0, async): state=IDLE, counter=0, MemReq=0, MemWe=0.
  - MemAddr, MemWData, all MEM/WB outputs, AddrError and BusError are 0.
- Non-memory instruction: 1-cycle latency EX/MEM→MEM/WB, no stall.
- Memory access with ack after k WAIT cycles (k≥1):
  - Stall is high for k cycles (the IDLE cycle plus k−1 WAIT cycles).
  - MEM/WB is valid k+1 cycles after the instruction enters.
- Minimum access: 1 stall cycle, MemReq high for exactly 1 cycle.
- MemReq, MemWe, MemAddr and MemWData are registered. They stay stable through WAIT and change only on state exit.
- Stall is combinational from state, inputs and MemAck. The upstream pipeline releases on the ack cycle, so the next instruction reaches the inputs on the first IDLE cycle.
- Back-to-back memory ops: the second op is seen in IDLE immediately after the first completes. Minimum throughput is 2 cycles per access.
- Reset asserted mid-WAIT: the request is abandoned immediately. A late MemAck after reset is ignored.

## Structure
- Shared package (mips_pkg):
  - state encoding constants IDLE=1'b0, WAIT=1'b1
  - bubble control values
  - word-alignment mask 2'b11
- Sub-module mem_wb_reg: the MEM/WB pipeline register (controls, ReadData, ALUResult, destination, load enable). It mirrors the existing per-field 1/5/32-bit register cells, with active-low async reset.
- FSM, latches and timeout counter live in mem_access_stage.

## Test plan
1. ADD result 0x0000_0010 to r8, no access → next cycle ALUResultOut=0x10, DestinationRegOut=8, RegWriteOut=1, Stall never high.
2. LW at 0x100, ack in first WAIT cycle with MemRData=0xDEAD_BEEF:
   - Stall high 1 cycle, MemReq high 1 cycle, MemAddr=0x100, MemWe=0.
   - Then ReadDataOut=0xDEAD_BEEF, MemToRegOut=1, RegWriteOut=1.
3. SW 0x1234_5678 at 0x200, ack after 4 WAIT cycles:
   - Stall high 4 cycles; MemWe=1 and MemWData=0x1234_5678 stable throughout.
   - Bubbles in MEM/WB meanwhile; final RegWriteOut=0.
4. LW at 0x102 → no MemReq, Stall=0, AddrError=1 for one cycle, RegWriteOut=0.
5. TIMEOUT_CYCLES=3, LW with no ack:
   - MemReq high 3 cycles, then drops; BusError pulses once; RegWriteOut=0.
   - Ack on the 3rd cycle instead → normal completion, no BusError.
6. rst pulled low during WAIT of an LW → MemReq, Stall and all outputs 0 immediately. After release, a stray MemAck has no effect.
